uart_cmd_ctrl: RTL and testbench
================================

# uart_cmd_ctrl

Command-frame controller placed directly behind `uart_rx`. It consumes the received byte stream (byte plus one-cycle valid pulse) and parses fixed-format command frames. It drives a simple register-bus write/read port and hands a one-byte response (ACK, NAK or read data) to the UART transmit path over a valid/ready handshake. It owns frame sequencing, checksum checking, inter-byte timeout and error accounting.

## Interface
- `CLK_FREQ`, 125000000, system clock in Hz
- `BAUD_RATE`, 115200, line rate, used only for the timeout
- `TIMEOUT_BYTES`, 4, inter-byte silence in byte-times that aborts a partial frame; TO_CYC = (CLK_FREQ/BAUD_RATE)*10*TIMEOUT_BYTES, 43400 at defaults
- `clk` in 1: single clock
- `reset` in 1: asynchronous, active-high
- `rx_byte` in 8: byte from `uart_rx`
- `rx_valid` in 1: one-cycle pulse, `rx_byte` valid
- `reg_addr` out 8: register address
- `reg_wr_data` out 8: write data
- `reg_wr_en` out 1: one-cycle write strobe
- `reg_rd_en` out 1: one-cycle read strobe
- `reg_rd_data` in 8: read data, valid exactly 1 cycle after `reg_rd_en`
- `tx_byte` out 8: response byte
- `tx_valid` out 1: response pending
- `tx_ready` in 1: transmitter accepts the byte when `tx_valid && tx_ready`
- `err_cnt` out 8: saturating error count
- `busy` out 1: high in any state other than IDLE

## Operation
- Frame format: SYNC=0xA5, CMD, ADDR, DATA (write only), CHK. CHK is the XOR of every byte from CMD through the last byte before CHK.
- CMD values: 0x01 write, 0x02 read. Any other CMD value is an error.
- States:
  - IDLE: a byte equal to 0xA5 moves to CMD. Any other byte is silently discarded.
  - CMD: a valid CMD moves to ADDR. An invalid CMD moves to RESP with NAK and increments `err_cnt`.
  - ADDR: stores the address. Write moves to DATA; read moves to CHK.
  - DATA: stores the write data and moves to CHK.
  - CHK: the byte is compared with the running XOR.
    - Mismatch: NAK, `err_cnt`+1, then RESP.
    - Write match: `reg_wr_en` pulses for 1 cycle, then RESP with ACK=0x06.
    - Read match: moves to RD.
  - RD: `reg_rd_en` pulses for 1 cycle. The next cycle latches `reg_rd_data` into `tx_byte` and moves to RESP.
  - RESP: `tx_valid` is held high until `tx_ready`, then the block returns to IDLE.
- NAK value is 0x15.
- `rx_valid` seen during RD or RESP: the byte is dropped and `err_cnt`+1. No resync is attempted.
- Timeout: a counter is cleared on every `rx_valid` and runs only in CMD, ADDR, DATA and CHK. When it reaches TO_CYC-1, the block returns to IDLE, `err_cnt`+1, and no response is sent.
- `err_cnt` saturates at 0xFF. It is cleared only by reset.
- Reset values:
  - State is IDLE.
  - `reg_wr_en`, `reg_rd_en`, `tx_valid` and `busy` are 0.
  - `reg_addr`, `reg_wr_data`, `tx_byte` and `err_cnt` are 0x00.
  - The running XOR and the timer are 0.
- Reset asserted mid-frame or during RESP drops the frame, clears all outputs immediately, and no strobe is issued.

## Timing
- Each byte is consumed on the cycle `rx_valid` is high. The state update is visible on the next edge.
- Write: `reg_wr_en` is high in the cycle after the CHK byte's `rx_valid`, with `reg_addr` and `reg_wr_data` stable. `tx_valid` (ACK) rises in the cycle after that.
- Read:
  - `reg_rd_en` is high 1 cycle after CHK is accepted.
  - `reg_rd_data` is sampled 1 cycle after `reg_rd_en`.
  - `tx_valid` rises in the cycle after the sample, 3 cycles after CHK's `rx_valid`.
- `tx_byte` is stable while `tx_valid` is high. `tx_valid` falls in the cycle after the handshake.
- An error in two events in the same cycle (for example a dropped byte and a timeout) increments `err_cnt` by 1 only.
- `rx_valid` arriving in the same cycle the timeout fires: the timeout wins and the byte is discarded. A 0xA5 is not treated as a new SYNC.

## Structure
- Shared package `uart_pkg`:
  - SYNC, CMD_WR, CMD_RD, ACK, NAK constants.
  - State enumeration.
  - TO_CYC formula as a function of CLK_FREQ, BAUD_RATE and TIMEOUT_BYTES.
- One sub-module, `uart_idle_timer`: `clear`, `enable` and `expired` ports, parameterised by TO_CYC, width $clog2(TO_CYC)+1.
- The FSM, XOR accumulator and error counter stay in `uart_cmd_ctrl`.

## Test plan
- Benches use CLK_FREQ=1000 and BAUD_RATE=100, giving TO_CYC=400.
- Write frame A5 01 10 3C 2D -> `reg_wr_en` pulses once with addr 0x10 and data 0x3C; `tx_byte`=0x06; `err_cnt`=0.
- Read frame A5 02 20 22, with `reg_rd_data`=0x5A a cycle after `reg_rd_en` -> `tx_byte`=0x5A; no `reg_wr_en`.
- A5 01 10 3C FF (bad CHK) -> no write strobe; `tx_byte`=0x15; `err_cnt`=1. Likewise A5 07 -> NAK and `err_cnt`=2.
- A5 01 10 followed by 400 idle cycles -> back to IDLE, `busy`=0, `err_cnt`+1, `tx_valid` stays 0. A following good write frame completes normally.
- `tx_ready` held low for 50 cycles while 2 bytes arrive -> `tx_valid` and `tx_byte` stay stable, `err_cnt`+2, and ACK is accepted when `tx_ready` rises. Async `reset` pulsed mid-DATA -> all outputs 0 without waiting for a clock edge.
- Garbage 00 FF 13 before a valid frame -> ignored, `err_cnt` unchanged, and the frame is processed.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, state encoding and timeout arithmetic for the UART command controller.
package uart_pkg;

  localparam logic [7:0] SYNC   = 8'hA5;
  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_CHK,
    ST_WR,
    ST_RD,
    ST_RD_LAT,
    ST_RESP
  } state_t;

  // One byte-time is ten bit periods (start + 8 data + stop).
  function automatic int to_cyc(input int clk_freq, input int baud_rate, input int timeout_bytes);
    return (clk_freq / baud_rate) * 10 * timeout_bytes;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte-stream, register-bus and response handshake bundle of the command controller.
interface uart_cmd_ctrl_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] reg_addr;
  logic [7:0] reg_wr_data;
  logic       reg_wr_en;
  logic       reg_rd_en;
  logic [7:0] reg_rd_data;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] err_cnt;
  logic       busy;

  modport master (
    input  rx_byte, rx_valid, reg_rd_data, tx_ready,
    output reg_addr, reg_wr_data, reg_wr_en, reg_rd_en, tx_byte, tx_valid, err_cnt, busy
  );

  modport slave (
    output rx_byte, rx_valid, reg_rd_data, tx_ready,
    input  reg_addr, reg_wr_data, reg_wr_en, reg_rd_en, tx_byte, tx_valid, err_cnt, busy
  );
endinterface

// File: rtl/uart_idle_timer.sv
// Inter-byte silence timer: counts enabled cycles since the last clear, flags the final cycle.
module uart_idle_timer #(
  parameter int TO_CYC = 43400
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TO_CYC) + 1;
  localparam logic [W-1:0] LAST = W'(TO_CYC - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clear || !enable)
      cnt <= '0;
    else if (cnt != LAST)
      cnt <= cnt + 1'b1;
  end

  // Independent of clear so a byte landing on the expiry cycle cannot rescue the frame.
  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame parser behind uart_rx: SYNC/CMD/ADDR/[DATA]/CHK -> register access and one-byte reply.
module uart_cmd_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ      = 125000000,
  parameter int BAUD_RATE     = 115200,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic            clk,
  input  logic            reset,
  uart_cmd_ctrl_if.master bus
);

  localparam int TO_CYC = to_cyc(CLK_FREQ, BAUD_RATE, TIMEOUT_BYTES);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     state, state_n;
  logic       is_wr, is_wr_n;
  logic [7:0] addr, addr_n;
  logic [7:0] wdata, wdata_n;
  logic       wr_en, wr_en_n;
  logic       rd_en, rd_en_n;
  logic [7:0] tx_byte, tx_byte_n;
  logic       tx_valid, tx_valid_n;
  logic [7:0] chk, chk_n;
  logic [7:0] err_cnt;
  logic       err_inc;
  logic       to_enable;
  logic       to_expired;

  assign to_enable = (state == ST_CMD) || (state == ST_ADDR) ||
                     (state == ST_DATA) || (state == ST_CHK);

  uart_idle_timer #(.TO_CYC(TO_CYC)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (bus.rx_valid),
    .enable  (to_enable),
    .expired (to_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      is_wr    <= 1'b0;
      addr     <= 8'h00;
      wdata    <= 8'h00;
      wr_en    <= 1'b0;
      rd_en    <= 1'b0;
      tx_byte  <= 8'h00;
      tx_valid <= 1'b0;
      chk      <= 8'h00;
      err_cnt  <= 8'h00;
    end else begin
      state    <= state_n;
      is_wr    <= is_wr_n;
      addr     <= addr_n;
      wdata    <= wdata_n;
      wr_en    <= wr_en_n;
      rd_en    <= rd_en_n;
      tx_byte  <= tx_byte_n;
      tx_valid <= tx_valid_n;
      chk      <= chk_n;
      if (err_inc)
        err_cnt <= sat_inc(err_cnt);
    end
  end

  always_comb begin
    state_n    = state;
    is_wr_n    = is_wr;
    addr_n     = addr;
    wdata_n    = wdata;
    wr_en_n    = 1'b0;
    rd_en_n    = 1'b0;
    tx_byte_n  = tx_byte;
    tx_valid_n = tx_valid;
    chk_n      = chk;
    err_inc    = 1'b0;

    if (to_expired) begin
      state_n = ST_IDLE;
      err_inc = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.rx_valid && bus.rx_byte == SYNC) begin
            state_n = ST_CMD;
            chk_n   = 8'h00;
          end
        end
        ST_CMD: begin
          if (bus.rx_valid) begin
            chk_n = bus.rx_byte;
            if (bus.rx_byte == CMD_WR || bus.rx_byte == CMD_RD) begin
              is_wr_n = (bus.rx_byte == CMD_WR);
              state_n = ST_ADDR;
            end else begin
              state_n    = ST_RESP;
              tx_byte_n  = NAK;
              tx_valid_n = 1'b1;
              err_inc    = 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (bus.rx_valid) begin
            addr_n  = bus.rx_byte;
            chk_n   = chk ^ bus.rx_byte;
            state_n = is_wr ? ST_DATA : ST_CHK;
          end
        end
        ST_DATA: begin
          if (bus.rx_valid) begin
            wdata_n = bus.rx_byte;
            chk_n   = chk ^ bus.rx_byte;
            state_n = ST_CHK;
          end
        end
        ST_CHK: begin
          if (bus.rx_valid) begin
            if (bus.rx_byte != chk) begin
              state_n    = ST_RESP;
              tx_byte_n  = NAK;
              tx_valid_n = 1'b1;
              err_inc    = 1'b1;
            end else if (is_wr) begin
              wr_en_n = 1'b1;
              state_n = ST_WR;
            end else begin
              rd_en_n = 1'b1;
              state_n = ST_RD;
            end
          end
        end
        ST_WR: begin
          err_inc    = bus.rx_valid;
          state_n    = ST_RESP;
          tx_byte_n  = ACK;
          tx_valid_n = 1'b1;
        end
        ST_RD: begin
          err_inc = bus.rx_valid;
          state_n = ST_RD_LAT;
        end
        // Register read data is only valid in the cycle after the strobe.
        ST_RD_LAT: begin
          err_inc    = bus.rx_valid;
          tx_byte_n  = bus.reg_rd_data;
          tx_valid_n = 1'b1;
          state_n    = ST_RESP;
        end
        ST_RESP: begin
          err_inc = bus.rx_valid;
          if (bus.tx_ready) begin
            tx_valid_n = 1'b0;
            state_n    = ST_IDLE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign bus.reg_addr    = addr;
  assign bus.reg_wr_data = wdata;
  assign bus.reg_wr_en   = wr_en;
  assign bus.reg_rd_en   = rd_en;
  assign bus.tx_byte     = tx_byte;
  assign bus.tx_valid    = tx_valid;
  assign bus.err_cnt     = err_cnt;
  assign bus.busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: directed frames plus random frames scored against a frame-level model.
module tb_uart_cmd_ctrl;

  logic clk;
  logic reset;
  uart_cmd_ctrl_if bus();

  uart_cmd_ctrl #(.CLK_FREQ(1000), .BAUD_RATE(100), .TIMEOUT_BYTES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Observed bus activity
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  int         tx_cnt = 0;
  logic [7:0] wr_addr_seen = 8'h00;
  logic [7:0] wr_data_seen = 8'h00;
  logic [7:0] tx_last = 8'h00;
  logic [7:0] rd_val = 8'h00;
  logic       rd_prev = 1'b0;

  // Model expectations
  int         exp_err = 0;
  int         exp_wr = 0;
  int         exp_rd = 0;
  int         exp_tx = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register responder provides data exactly one cycle after the read strobe.
  always @(negedge clk) begin
    if (bus.reg_wr_en) begin
      wr_cnt++;
      wr_addr_seen = bus.reg_addr;
      wr_data_seen = bus.reg_wr_data;
    end
    if (bus.reg_rd_en) rd_cnt++;
    if (bus.tx_valid && bus.tx_ready) begin
      tx_cnt++;
      tx_last = bus.tx_byte;
    end
    bus.reg_rd_data = rd_prev ? rd_val : 8'hEE;
    rd_prev = bus.reg_rd_en;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_byte = 8'h00;
    bus.tx_ready = 1'b1;
    tick(3);
    n_checks++; if (bus.reg_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h want 00", bus.reg_addr); end
    n_checks++; if (bus.reg_wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wdata got %h want 00", bus.reg_wr_data); end
    n_checks++; if (bus.reg_wr_en !== 1'b0 || bus.reg_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_strobes got %b%b want 00", bus.reg_wr_en, bus.reg_rd_en); end
    n_checks++; if (bus.tx_valid !== 1'b0 || bus.tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_tx got %b/%h want 0/00", bus.tx_valid, bus.tx_byte); end
    n_checks++; if (bus.err_cnt !== 8'h00 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_err_busy got %h/%b want 00/0", bus.err_cnt, bus.busy); end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_write;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h3C); send_byte(8'h2D);
    n_checks++; if (bus.reg_wr_en !== 1'b1 || bus.reg_addr !== 8'h10 || bus.reg_wr_data !== 8'h3C)
      begin n_fail++; $display("FAIL write_strobe got en=%b a=%h d=%h want 1/10/3c", bus.reg_wr_en, bus.reg_addr, bus.reg_wr_data); end
    n_checks++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL write_tx_early got %b want 0", bus.tx_valid); end
    tick(1);
    n_checks++; if (bus.reg_wr_en !== 1'b0 || bus.tx_valid !== 1'b1 || bus.tx_byte !== 8'h06)
      begin n_fail++; $display("FAIL write_ack got en=%b v=%b b=%h want 0/1/06", bus.reg_wr_en, bus.tx_valid, bus.tx_byte); end
    tick(1);
    exp_wr++; exp_tx++;
    n_checks++; if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL write_done got v=%b busy=%b want 0/0", bus.tx_valid, bus.busy); end
    n_checks++; if (wr_cnt !== exp_wr || tx_last !== 8'h06 || bus.err_cnt !== 8'(exp_err))
      begin n_fail++; $display("FAIL write_summary got wr=%0d tx=%h err=%0d want %0d/06/%0d", wr_cnt, tx_last, bus.err_cnt, exp_wr, exp_err); end
  endtask

  task automatic test_read;
    rd_val = 8'h5A;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h20); send_byte(8'h22);
    n_checks++; if (bus.reg_rd_en !== 1'b1) begin n_fail++; $display("FAIL read_strobe got %b want 1", bus.reg_rd_en); end
    tick(1);
    n_checks++; if (bus.reg_rd_en !== 1'b0 || bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL read_wait got en=%b v=%b want 0/0", bus.reg_rd_en, bus.tx_valid); end
    tick(1);
    n_checks++; if (bus.tx_valid !== 1'b1 || bus.tx_byte !== 8'h5A) begin n_fail++; $display("FAIL read_resp got v=%b b=%h want 1/5a", bus.tx_valid, bus.tx_byte); end
    tick(2);
    exp_rd++; exp_tx++;
    n_checks++; if (rd_cnt !== exp_rd || wr_cnt !== exp_wr || tx_last !== 8'h5A)
      begin n_fail++; $display("FAIL read_summary got rd=%0d wr=%0d tx=%h want %0d/%0d/5a", rd_cnt, wr_cnt, tx_last, exp_rd, exp_wr); end
  endtask

  task automatic test_nak;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h3C); send_byte(8'hFF);
    tick(3);
    exp_err++; exp_tx++;
    n_checks++; if (wr_cnt !== exp_wr || tx_last !== 8'h15 || bus.err_cnt !== 8'(exp_err))
      begin n_fail++; $display("FAIL bad_chk got wr=%0d tx=%h err=%0d want %0d/15/%0d", wr_cnt, tx_last, bus.err_cnt, exp_wr, exp_err); end
    send_byte(8'hA5); send_byte(8'h07);
    tick(3);
    exp_err++; exp_tx++;
    n_checks++; if (tx_cnt !== exp_tx || tx_last !== 8'h15 || bus.err_cnt !== 8'(exp_err))
      begin n_fail++; $display("FAIL bad_cmd got n=%0d tx=%h err=%0d want %0d/15/%0d", tx_cnt, tx_last, bus.err_cnt, exp_tx, exp_err); end
  endtask

  task automatic test_timeout;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
    tick(395);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL timeout_early got busy=%b want 1", bus.busy); end
    tick(10);
    exp_err++;
    n_checks++; if (bus.busy !== 1'b0 || bus.err_cnt !== 8'(exp_err) || tx_cnt !== exp_tx || bus.tx_valid !== 1'b0)
      begin n_fail++; $display("FAIL timeout got busy=%b err=%0d n=%0d v=%b want 0/%0d/%0d/0", bus.busy, bus.err_cnt, tx_cnt, bus.tx_valid, exp_err, exp_tx); end
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h3C); send_byte(8'h2D);
    tick(3);
    exp_wr++; exp_tx++;
    n_checks++; if (wr_cnt !== exp_wr || tx_last !== 8'h06 || bus.err_cnt !== 8'(exp_err))
      begin n_fail++; $display("FAIL after_timeout got wr=%0d tx=%h err=%0d want %0d/06/%0d", wr_cnt, tx_last, bus.err_cnt, exp_wr, exp_err); end
  endtask

  task automatic test_timeout_collision;
    send_byte(8'hA5); send_byte(8'h01);
    tick(399);
    send_byte(8'hA5);
    exp_err++;
    n_checks++; if (bus.busy !== 1'b0 || bus.err_cnt !== 8'(exp_err))
      begin n_fail++; $display("FAIL timeout_collision got busy=%b err=%0d want 0/%0d", bus.busy, bus.err_cnt, exp_err); end
    tick(2);
  endtask

  task automatic test_back_pressure;
    bus.tx_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h44); send_byte(8'h99); send_byte(8'hDC);
    tick(3);
    tick(20); send_byte(8'h55);
    tick(20); send_byte(8'hA5);
    tick(8);
    exp_err += 2; exp_wr++;
    n_checks++; if (bus.tx_valid !== 1'b1 || bus.tx_byte !== 8'h06 || tx_cnt !== exp_tx)
      begin n_fail++; $display("FAIL stall_hold got v=%b b=%h n=%0d want 1/06/%0d", bus.tx_valid, bus.tx_byte, tx_cnt, exp_tx); end
    n_checks++; if (bus.err_cnt !== 8'(exp_err) || wr_addr_seen !== 8'h44 || wr_data_seen !== 8'h99)
      begin n_fail++; $display("FAIL stall_err got err=%0d a=%h d=%h want %0d/44/99", bus.err_cnt, wr_addr_seen, wr_data_seen, exp_err); end
    bus.tx_ready = 1'b1;
    tick(1);
    exp_tx++;
    n_checks++; if (tx_cnt !== exp_tx || tx_last !== 8'h06 || bus.tx_valid !== 1'b0 || bus.busy !== 1'b0)
      begin n_fail++; $display("FAIL stall_release got n=%0d tx=%h v=%b busy=%b want %0d/06/0/0", tx_cnt, tx_last, bus.tx_valid, bus.busy, exp_tx); end
  endtask

  task automatic test_garbage;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h13);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h81);
    send_byte(8'h01 ^ 8'h7E ^ 8'h81);
    tick(3);
    exp_wr++; exp_tx++;
    n_checks++; if (wr_cnt !== exp_wr || wr_addr_seen !== 8'h7E || wr_data_seen !== 8'h81 || bus.err_cnt !== 8'(exp_err))
      begin n_fail++; $display("FAIL garbage got wr=%0d a=%h d=%h err=%0d want %0d/7e/81/%0d", wr_cnt, wr_addr_seen, wr_data_seen, bus.err_cnt, exp_wr, exp_err); end
  endtask

  task automatic test_random;
    logic [7:0] cmd, addr, data, good, chk, exp_byte;
    int r;
    for (int f = 0; f < 40; f++) begin
      r = $urandom_range(0, 9);
      cmd = (r < 4) ? 8'h01 : (r < 8) ? 8'h02 : 8'($urandom_range(3, 255));
      addr = 8'($urandom);
      data = 8'($urandom);
      rd_val = 8'($urandom);
      send_byte(8'hA5);
      tick($urandom_range(0, 3));
      send_byte(cmd);
      if (cmd != 8'h01 && cmd != 8'h02) begin
        exp_byte = 8'h15;
        exp_err++;
      end else begin
        good = cmd ^ addr ^ ((cmd == 8'h01) ? data : 8'h00);
        chk = ($urandom_range(0, 4) == 0) ? (good ^ 8'($urandom_range(1, 255))) : good;
        tick($urandom_range(0, 3));
        send_byte(addr);
        if (cmd == 8'h01) begin
          tick($urandom_range(0, 3));
          send_byte(data);
        end
        tick($urandom_range(0, 3));
        send_byte(chk);
        if (chk != good) begin
          exp_byte = 8'h15;
          exp_err++;
        end else if (cmd == 8'h01) begin
          exp_byte = 8'h06;
          exp_wr++;
        end else begin
          exp_byte = rd_val;
          exp_rd++;
        end
      end
      exp_tx++;
      tick(6);
      n_checks++; if (tx_cnt !== exp_tx || tx_last !== exp_byte)
        begin n_fail++; $display("FAIL rand_resp[%0d] got n=%0d tx=%h want %0d/%h", f, tx_cnt, tx_last, exp_tx, exp_byte); end
      n_checks++; if (wr_cnt !== exp_wr || rd_cnt !== exp_rd || bus.err_cnt !== 8'(exp_err))
        begin n_fail++; $display("FAIL rand_counts[%0d] got wr=%0d rd=%0d err=%0d want %0d/%0d/%0d", f, wr_cnt, rd_cnt, bus.err_cnt, exp_wr, exp_rd, exp_err); end
      if (cmd == 8'h01 && chk == good) begin
        n_checks++; if (wr_addr_seen !== addr || wr_data_seen !== data)
          begin n_fail++; $display("FAIL rand_wr[%0d] got a=%h d=%h want %h/%h", f, wr_addr_seen, wr_data_seen, addr, data); end
      end
    end
  endtask

  task automatic test_saturate;
    bus.tx_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h07);
    tick(2);
    for (int i = 0; i < 260; i++) send_byte(8'($urandom));
    exp_err = exp_err + 1 + 260;
    if (exp_err > 255) exp_err = 255;
    n_checks++; if (bus.err_cnt !== 8'(exp_err) || bus.tx_byte !== 8'h15 || bus.tx_valid !== 1'b1)
      begin n_fail++; $display("FAIL saturate got err=%0d b=%h v=%b want %0d/15/1", bus.err_cnt, bus.tx_byte, bus.tx_valid, exp_err); end
    bus.tx_ready = 1'b1;
    tick(2);
    exp_tx++;
  endtask

  task automatic test_reset_mid_frame;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.err_cnt !== 8'h00 || bus.reg_addr !== 8'h00)
      begin n_fail++; $display("FAIL async_reset got busy=%b err=%h a=%h want 0/00/00", bus.busy, bus.err_cnt, bus.reg_addr); end
    n_checks++; if (bus.tx_valid !== 1'b0 || bus.tx_byte !== 8'h00 || bus.reg_wr_data !== 8'h00)
      begin n_fail++; $display("FAIL async_reset_tx got v=%b b=%h d=%h want 0/00/00", bus.tx_valid, bus.tx_byte, bus.reg_wr_data); end
    tick(2);
    reset = 1'b0;
    exp_err = 0;
    send_byte(8'h3C); send_byte(8'h2D);
    tick(4);
    n_checks++; if (wr_cnt !== exp_wr || tx_cnt !== exp_tx || bus.busy !== 1'b0)
      begin n_fail++; $display("FAIL after_reset got wr=%0d n=%0d busy=%b want %0d/%0d/0", wr_cnt, tx_cnt, bus.busy, exp_wr, exp_tx); end
  endtask

  initial begin
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_byte = 8'h00;
    bus.tx_ready = 1'b1;
    test_reset;
    test_write;
    test_read;
    test_nak;
    test_timeout;
    test_timeout_collision;
    test_back_pressure;
    test_garbage;
    test_random;
    test_saturate;
    test_reset_mid_frame;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
